// File: rtl/uart_ack_sender.sv
// UART transmitter with acknowledge handshake: sends one byte, waits for an ACK byte,
// retransmits on timeout up to a bounded count, and reports done/fail.
module uart_ack_sender #(
    parameter int                    CLK_FREQ              = 50_000_000,
    parameter int                    UART_WIDTH            = 8,
    parameter int                    UART_BAUD_RATE        = 230400,
    parameter int                    ACK_TIMEOUT           = 1,
    parameter int                    UART_RETRANSMIT_COUNT = 5,
    parameter logic [UART_WIDTH-1:0] UART_ACK              = 8'b11001100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [UART_WIDTH-1:0] data_in,
    input  logic                  send,
    output logic                  ready,
    output logic                  tx,
    input  logic [UART_WIDTH-1:0] ack_byte,
    input  logic                  ack_valid,
    output logic                  done,
    output logic                  fail,
    output logic [2:0]            attempts
);

    localparam int CLKS_PER_BIT   = CLK_FREQ / UART_BAUD_RATE;
    localparam int TIMEOUT_CYCLES = (CLK_FREQ / 1000) * ACK_TIMEOUT;
    localparam int CW = (CLKS_PER_BIT > 1)   ? $clog2(CLKS_PER_BIT)   : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BW = (UART_WIDTH > 1)     ? $clog2(UART_WIDTH)     : 1;

    localparam logic [CW-1:0] CLK_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST     = BW'(UART_WIDTH - 1);
    localparam logic [2:0]    MAX_ATTEMPTS = 3'(1 + UART_RETRANSMIT_COUNT);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] START    = 3'd1;
    localparam logic [2:0] DATA     = 3'd2;
    localparam logic [2:0] STOP     = 3'd3;
    localparam logic [2:0] WAIT_ACK = 3'd4;

    logic [2:0]            state_reg;
    logic [UART_WIDTH-1:0] data_reg;
    logic [UART_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         clk_cnt_reg;
    logic [BW-1:0]         bit_idx_reg;
    logic [TW-1:0]         timer_reg;
    logic [2:0]            attempts_reg;
    logic                  tx_reg;
    logic                  done_reg;
    logic                  fail_reg;

    // Holding ready low during the done/fail pulse makes ready rise the cycle after it.
    assign ready    = (state_reg == IDLE) && !done_reg && !fail_reg;
    assign tx       = tx_reg;
    assign done     = done_reg;
    assign fail     = fail_reg;
    assign attempts = attempts_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            data_reg     <= '0;
            shift_reg    <= '0;
            clk_cnt_reg  <= '0;
            bit_idx_reg  <= '0;
            timer_reg    <= '0;
            attempts_reg <= 3'd0;
            tx_reg       <= 1'b1;
            done_reg     <= 1'b0;
            fail_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            fail_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (send && ready) begin
                        data_reg     <= data_in;
                        shift_reg    <= data_in;
                        attempts_reg <= 3'd1;
                        clk_cnt_reg  <= '0;
                        tx_reg       <= 1'b0;
                        state_reg    <= START;
                    end
                end
                START: begin
                    if (clk_cnt_reg == CLK_LAST) begin
                        clk_cnt_reg <= '0;
                        bit_idx_reg <= '0;
                        tx_reg      <= shift_reg[0];
                        shift_reg   <= shift_reg >> 1;
                        state_reg   <= DATA;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt_reg == CLK_LAST) begin
                        clk_cnt_reg <= '0;
                        if (bit_idx_reg == BIT_LAST) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                            tx_reg      <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt_reg == CLK_LAST) begin
                        clk_cnt_reg <= '0;
                        timer_reg   <= '0;
                        state_reg   <= WAIT_ACK;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end
                WAIT_ACK: begin
                    // A matching ACK takes priority over an expiring timeout.
                    if (ack_valid && (ack_byte == UART_ACK)) begin
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end else if (timer_reg == TIMER_LAST) begin
                        if (attempts_reg < MAX_ATTEMPTS) begin
                            attempts_reg <= attempts_reg + 1'b1;
                            shift_reg    <= data_reg;
                            clk_cnt_reg  <= '0;
                            tx_reg       <= 1'b0;
                            state_reg    <= START;
                        end else begin
                            fail_reg  <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
